// File: rtl/gf8_barrett_mul_if.sv
`default_nettype none
// ============================================================================
//  Module      : gf8_barrett_mul_if
//  Description : Operand / result handshake bundle for gf8_barrett_mul.
//                The master drives the operands, the polynomial load and
//                out_ready. The slave (the multiplier) returns the handshake
//                status and the reduced product.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gf8_barrett_mul_if;
    logic       poly_ld;
    logic [7:0] poly_in;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       busy;

    modport master (
        output poly_ld, poly_in, in_valid, a, b, out_ready,
        input  in_ready, out_valid, y, busy
    );

    modport slave (
        input  poly_ld, poly_in, in_valid, a, b, out_ready,
        output in_ready, out_valid, y, busy
    );
endinterface
`default_nettype wire

// File: rtl/gf8_barrett_mul.sv
`default_nettype none
// ============================================================================
//  Module      : gf8_barrett_mul
//  Description : Sequential GF(2^8) multiplier, y = a*b mod (x^8 + poly).
//                One shared 8x9 carry-less multiplier is reused for the full
//                product, the Barrett quotient estimate and the reduction.
//                Loading a new polynomial runs a 9-cycle bit-serial long
//                division that produces mu = floor(x^16 / P).
//                Build option GF8_FIXED_AES_EN: polynomial fixed to the AES
//                field (0x11B), no polynomial load and no division logic.
//  Revision    : 1.0 - initial release
// ============================================================================
module gf8_barrett_mul (
    input  wire logic        clk,
    input  wire logic        rst_n,
    gf8_barrett_mul_if.slave bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
`ifndef GF8_FIXED_AES_EN
    localparam logic [2:0] S_MU   = 3'd1;
`endif
    localparam logic [2:0] S_MUL  = 3'd2;
    localparam logic [2:0] S_QUO  = 3'd3;
    localparam logic [2:0] S_RED  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [7:0] AES_POLY = 8'h1B;
    localparam logic [8:0] AES_MU   = 9'h11A;

    // Carry-less product. Every operand pairing used here has degree <= 14,
    // so a 15-bit result never drops a coefficient.
    function automatic logic [14:0] clmul8x9(input logic [7:0] x, input logic [8:0] z);
        logic [14:0] acc;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            if (x[i]) acc = acc ^ ({6'd0, z} << i);
        end
        return acc;
    endfunction

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [14:0] r_c;
    logic [6:0]  r_q;
    logic [7:0]  r_y;
    logic [7:0]  w_poly;
    logic [8:0]  w_mu;
    logic        w_ld_req;
    logic        w_ld_go;
    logic        w_mu_last;
    logic        w_accept;
    logic [7:0]  w_op_x;
    logic [8:0]  w_op_z;
    logic [14:0] w_prod;

`ifdef GF8_FIXED_AES_EN
    logic w_unused_poly;
    assign w_unused_poly = ^{bus.poly_ld, bus.poly_in};
    assign w_poly    = AES_POLY;
    assign w_mu      = AES_MU;
    assign w_ld_req  = 1'b0;
    assign w_mu_last = 1'b0;
`else
    logic [7:0] r_poly;
    logic [8:0] r_mu;
    logic [7:0] r_rem;
    logic [3:0] r_cnt;

    assign w_poly    = r_poly;
    assign w_mu      = r_mu;
    assign w_ld_req  = bus.poly_ld;
    assign w_mu_last = (r_state == S_MU) && (r_cnt == 4'd8);

    // Polynomial load and bit-serial division of x^16 by {1, poly}. The top
    // eight dividend bits (1 then zeros) seed the remainder as 0x80; each MU
    // cycle brings down one zero and shifts one quotient bit into mu, MSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_poly <= AES_POLY;
            r_mu   <= AES_MU;
            r_rem  <= 8'h00;
            r_cnt  <= 4'd0;
        end else if (w_ld_go) begin
            r_poly <= bus.poly_in;
            r_rem  <= 8'h80;
            r_cnt  <= 4'd0;
        end else if (r_state == S_MU) begin
            r_rem  <= {r_rem[6:0], 1'b0} ^ (r_rem[7] ? r_poly : 8'h00);
            r_mu   <= {r_mu[7:0], r_rem[7]};
            r_cnt  <= r_cnt + 4'd1;
        end
    end
`endif

    assign w_ld_go  = (r_state == S_IDLE) && w_ld_req;
    assign w_accept = bus.in_valid && bus.in_ready;

    // Shared multiplier operand selection by phase.
    always_comb begin
        w_op_x = 8'd0;
        w_op_z = 9'd0;
        case (r_state)
            S_MUL: begin
                w_op_x = r_a;
                w_op_z = {1'b0, r_b};
            end
            S_QUO: begin
                w_op_x = {1'b0, r_c[14:8]};
                w_op_z = w_mu;
            end
            S_RED: begin
                w_op_x = {1'b0, r_q};
                w_op_z = {1'b0, w_poly};
            end
            default: ;
        endcase
    end

    assign w_prod = clmul8x9(w_op_x, w_op_z);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; a polynomial load wins over a same-cycle operand.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_ld_go)           w_state_nxt = r_state + 3'd1;
                else if (bus.in_valid) w_state_nxt = S_MUL;
            end
`ifndef GF8_FIXED_AES_EN
            S_MU:    if (w_mu_last) w_state_nxt = S_IDLE;
`endif
            S_MUL:   w_state_nxt = S_QUO;
            S_QUO:   w_state_nxt = S_RED;
            S_RED:   w_state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        bus.in_ready  = (r_state == S_IDLE) && !w_ld_req;
        bus.busy      = (r_state != S_IDLE);
        bus.out_valid = (r_state == S_DONE);
    end

    // Datapath registers: operands, full product, quotient, reduced result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= 8'h00;
            r_b <= 8'h00;
            r_c <= 15'h0000;
            r_q <= 7'h00;
            r_y <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_a <= bus.a;
                    r_b <= bus.b;
                end
                S_MUL:   r_c <= w_prod;
                S_QUO:   r_q <= w_prod[14:8];
                S_RED:   r_y <= r_c[7:0] ^ w_prod[7:0];
                default: ;
            endcase
        end
    end

    assign bus.y = r_y;

endmodule
`default_nettype wire

// File: tb/tb_gf8_barrett_mul.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_gf8_barrett_mul
//  Description : Self-checking bench for gf8_barrett_mul. A cycle-level
//                protocol model (reference field multiply by shift-and-reduce)
//                is compared against the DUT on every falling edge, alongside
//                directed vectors with hand-computed results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gf8_barrett_mul;

`ifdef GF8_FIXED_AES_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gf8_barrett_mul_if bus();

    gf8_barrett_mul dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int last_wait;
    int last_lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain carry-less product, then long-division remainder mod {1,p}.
    function automatic logic [7:0] gf_ref(input logic [7:0] x, input logic [7:0] z, input logic [7:0] p);
        logic [15:0] prod;
        prod = 16'h0000;
        for (int i = 0; i < 8; i++)
            if (z[i]) prod = prod ^ ({8'h00, x} << i);
        for (int d = 14; d >= 8; d--)
            if (prod[d]) prod = prod ^ ({7'd0, 1'b1, p} << (d - 8));
        return prod[7:0];
    endfunction

    // Protocol model: op_phase 0 = free, 1..3 = cycles since accept, 4 = result held.
    initial begin : model
        logic [7:0] m_poly;
        logic [7:0] m_y;
        int         m_op;
        int         m_mu;
        m_poly = 8'h1B; m_y = 8'h00; m_op = 0; m_mu = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_poly = 8'h1B; m_y = 8'h00; m_op = 0; m_mu = 0;
            end else begin
                check("m_in_ready", bus.in_ready,
                      (m_op == 0 && m_mu == 0 && !(!FIXED && bus.poly_ld)));
                check("m_busy", bus.busy, (m_op != 0 || m_mu != 0));
                check("m_out_valid", bus.out_valid, (m_op == 4));
                if (m_op == 4) check("m_y", bus.y, m_y);
                if (m_mu > 0) begin
                    m_mu--;
                end else if (m_op == 0) begin
                    if (!FIXED && bus.poly_ld) begin
                        m_poly = bus.poly_in;
                        m_mu   = 9;
                    end else if (bus.in_valid) begin
                        m_y  = gf_ref(bus.a, bus.b, m_poly);
                        m_op = 1;
                    end
                end else if (m_op < 4) begin
                    m_op++;
                end else if (bus.out_ready) begin
                    m_op = 0;
                end
            end
        end
    end

    // Issue one operation; starts and ends just after a rising edge.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic [7:0] exp, input bit lit, input string nm);
        int k;
        bus.a = ta; bus.b = tb_v; bus.in_valid = 1'b1;
        k = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            k++;
            if (k > 50) begin
                check({nm, "_accept_timeout"}, 32'd0, 32'd1);
                bus.in_valid = 1'b0; bus.poly_ld = 1'b0;
                return;
            end
            @(posedge clk); #1;
            bus.poly_ld = 1'b0;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.poly_ld = 1'b0;
        last_wait = k;
        k = 0;
        while (!bus.out_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        last_lat = k;
        if (k >= 20) check({nm, "_result_timeout"}, 32'd0, 32'd1);
        if (lit) check(nm, bus.y, exp);
        if (bus.out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic load_poly(input logic [7:0] p, output int nbusy);
        bus.poly_ld = 1'b1; bus.poly_in = p;
        @(posedge clk); #1;
        bus.poly_ld = 1'b0;
        nbusy = 0;
        while (bus.busy && nbusy < 40) begin
            @(posedge clk); #1;
            nbusy++;
        end
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int nb;
        int seen;
        logic [7:0] rp;
        bus.poly_ld = 1'b0; bus.poly_in = 8'h00; bus.in_valid = 1'b0;
        bus.a = 8'h00; bus.b = 8'h00; bus.out_ready = 1'b1;

        // Pin the reference model with hand-computed products.
        check("ref_57_83_aes", gf_ref(8'h57, 8'h83, 8'h1B), 8'hC1);
        check("ref_02_80_11d", gf_ref(8'h02, 8'h80, 8'h1D), 8'h1D);
        check("ref_80_80_11d", gf_ref(8'h80, 8'h80, 8'h1D), 8'h13);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_y", bus.y, 8'h00);
        @(posedge clk); #1;

        // AES field vectors.
        do_op(8'h57, 8'h83, 8'hC1, 1'b1, "aes_57_83");
        check("lat_57_83", last_lat, 3);
        do_op(8'h57, 8'h13, 8'hFE, 1'b1, "aes_57_13");
        do_op(8'h02, 8'h87, 8'h15, 1'b1, "aes_02_87");
        do_op(8'h00, 8'hFF, 8'h00, 1'b1, "aes_00_ff");
        do_op(8'h01, 8'hA5, 8'hA5, 1'b1, "aes_01_a5");

        // Backpressure: result held 20 cycles while new operands are offered.
        bus.out_ready = 1'b0;
        do_op(8'h57, 8'h13, 8'hFE, 1'b1, "bp_y");
        bus.a = 8'h11; bus.b = 8'h22; bus.in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("bp_hold_valid", bus.out_valid, 1);
            check("bp_hold_y", bus.y, 8'hFE);
            check("bp_in_ready", bus.in_ready, 0);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", bus.out_valid, 0);
        check("bp_release_busy", bus.busy, 0);

        // Programmable polynomial 0x11D.
        load_poly(8'h1D, nb);
        check("mu_busy_cycles", nb, FIXED ? 0 : 9);
        do_op(8'h02, 8'h80, FIXED ? 8'h1B : 8'h1D, 1'b1, "p11d_02_80");
        do_op(8'h80, 8'h80, FIXED ? 8'h9A : 8'h13, 1'b1, "p11d_80_80");

        // Reset while in QUO: no result, polynomial back to AES.
        bus.a = 8'h57; bus.b = 8'h83; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("rst_mid_quo_no_valid", seen, 0);
        @(posedge clk); #1;
        do_op(8'h02, 8'h80, 8'h1B, 1'b1, "rst_aes_02_80");
        do_op(8'h80, 8'h80, 8'h9A, 1'b1, "rst_aes_80_80");

        // Same-cycle poly_ld and in_valid: operands wait for the division.
        bus.poly_ld = 1'b1; bus.poly_in = 8'h1B;
        do_op(8'h57, 8'h83, 8'hC1, 1'b1, "ld_and_op_y");
        check("ld_and_op_wait", last_wait, FIXED ? 0 : 10);

        // Random operands over several random polynomials.
        for (int p = 0; p < 5; p++) begin
            rp = 8'($urandom_range(0, 255));
            load_poly(rp, nb);
            for (int n = 0; n < 1000; n++) begin
                do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'h00, 1'b0, "rnd");
            end
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
